gate_bist: RTL and testbench

Synthesizable exhaustive tester for a 2-input combinational gate; the on-chip counterpart of a stimulus/monitor bench. On start it drives all four {a,b} input vectors into the DUT and waits a programmable settle time. It then samples the DUT output, compares it against a parameterised truth table, and reports pass/fail, mismatch count and a per-vector failure map. It sits beside any lab gate (NAND/AND/OR/XOR) and needs only one clock.

---
 rtl/gate_bist_pkg.sv | 29 ++
 rtl/gate_bist_if.sv | 26 ++
 rtl/gate_bist_settle_timer.sv | 29 ++
 rtl/gate_bist.sv | 113 +++++++++++
 tb/tb_gate_bist.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the exhaustive 2-input gate tester.
// Truth tables are indexed by {a,b}; bit k is the expected output for vector k.
package gate_bist_pkg;

  localparam int unsigned NUM_VEC = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned ERR_W   = 3;
  localparam int unsigned CNT_W   = 4;

  localparam logic [NUM_VEC-1:0] TT_NAND = 4'b0111;
  localparam logic [NUM_VEC-1:0] TT_AND  = 4'b1000;
  localparam logic [NUM_VEC-1:0] TT_OR   = 4'b1110;
  localparam logic [NUM_VEC-1:0] TT_XOR  = 4'b0110;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Result bundle reported after each sweep
  typedef struct packed {
    logic               pass;
    logic [ERR_W-1:0]   err_count;
    logic [NUM_VEC-1:0] fail_vec;
  } result_t;

endpackage

// File: rtl/gate_bist_if.sv
// Control/observation bundle between the tester and its environment.
// The slave side is the tester; the master side drives start and the gate output.
interface gate_bist_if;
  import gate_bist_pkg::*;

  logic               start;
  logic               dut_y;
  logic               dut_a;
  logic               dut_b;
  logic               busy;
  logic               done;
  logic               pass;
  logic [ERR_W-1:0]   err_count;
  logic [NUM_VEC-1:0] fail_vec;

  modport master (
    output start, dut_y,
    input  dut_a, dut_b, busy, done, pass, err_count, fail_vec
  );

  modport slave (
    input  start, dut_y,
    output dut_a, dut_b, busy, done, pass, err_count, fail_vec
  );

endinterface

// File: rtl/gate_bist_settle_timer.sv
// Settle counter: restarts from zero on load, saturates at SETTLE-1.
// expire is high while the counter sits at its terminal value.
module gate_bist_settle_timer
  import gate_bist_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE - 1);

  logic [CNT_W-1:0] cnt;

  // Saturation keeps the counter parked while the FSM is idle
  always_ff @(posedge clk) begin
    if (rst || load) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expire = (cnt == LAST);

endmodule

// File: rtl/gate_bist.sv
// Exhaustive tester for a 2-input combinational gate: sweeps all four {a,b}
// vectors, samples after a settle time and reports pass, count and failure map.
module gate_bist
  import gate_bist_pkg::*;
#(
  parameter logic [NUM_VEC-1:0] TRUTH  = TT_NAND,
  parameter int unsigned        SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst,
  gate_bist_if.slave  bus
);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             busy, busy_nxt;
  logic             done, done_nxt;
  result_t          res, res_nxt;
  logic             load_c;
  logic             miss_c;
  logic             expire;

  gate_bist_settle_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (load_c),
    .expire (expire)
  );

  // Case inequality so that an X/Z gate output counts as a mismatch in simulation
  assign miss_c = (bus.dut_y !== TRUTH[idx]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      res   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      res   <= res_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    res_nxt   = res;
    load_c    = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = APPLY;
          idx_nxt   = '0;
          busy_nxt  = 1'b1;
          res_nxt   = '0;
          load_c    = 1'b1;
        end
      end

      APPLY: begin
        if (expire) begin
          state_nxt = SAMPLE;
        end
      end

      SAMPLE: begin
        if (miss_c) begin
          res_nxt.fail_vec[idx] = 1'b1;
          res_nxt.err_count     = res.err_count + ERR_W'(1);
        end
        if (idx == IDX_W'(NUM_VEC - 1)) begin
          // Final vector: pass must see this sample's update
          state_nxt    = DONE;
          busy_nxt     = 1'b0;
          done_nxt     = 1'b1;
          res_nxt.pass = (res_nxt.err_count == '0);
        end else begin
          state_nxt = APPLY;
          idx_nxt   = idx + IDX_W'(1);
          load_c    = 1'b1;
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // The vector index doubles as the gate drive; it holds 11 after a sweep
  assign bus.dut_a     = idx[1];
  assign bus.dut_b     = idx[0];
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.pass      = res.pass;
  assign bus.err_count = res.err_count;
  assign bus.fail_vec  = res.fail_vec;

endmodule

// File: tb/tb_gate_bist.sv
// Bench for gate_bist: three tester instances (NAND/2, AND/2, NAND/4) each
// driving a behavioural gate whose personality the stimulus can change.
module tb_gate_bist;
  import gate_bist_pkg::*;

  localparam int N_INST      = 3;
  localparam int MODE_NAND   = 0;
  localparam int MODE_STUCK1 = 1;
  localparam int MODE_AND    = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N_INST-1:0]  start;
  int                 mode [N_INST];
  logic [N_INST-1:0]  o_a, o_b, o_busy, o_done, o_pass;
  logic [ERR_W-1:0]   o_err [N_INST];
  logic [NUM_VEC-1:0] o_fv  [N_INST];

  int checks = 0;
  int errors = 0;

  function automatic logic gate(input int m, input logic a, input logic b);
    case (m)
      MODE_STUCK1: return 1'b1;
      MODE_AND:    return a & b;
      default:     return ~(a & b);
    endcase
  endfunction

  gate_bist_if bus0 ();
  gate_bist_if bus1 ();
  gate_bist_if bus2 ();

  gate_bist #(.TRUTH(TT_NAND), .SETTLE(2)) u_nand (.clk(clk), .rst(rst), .bus(bus0));
  gate_bist #(.TRUTH(TT_AND),  .SETTLE(2)) u_and  (.clk(clk), .rst(rst), .bus(bus1));
  gate_bist #(.TRUTH(TT_NAND), .SETTLE(4)) u_s4   (.clk(clk), .rst(rst), .bus(bus2));

  assign bus0.start = start[0];
  assign bus1.start = start[1];
  assign bus2.start = start[2];
  assign bus0.dut_y = gate(mode[0], bus0.dut_a, bus0.dut_b);
  assign bus1.dut_y = gate(mode[1], bus1.dut_a, bus1.dut_b);
  assign bus2.dut_y = gate(mode[2], bus2.dut_a, bus2.dut_b);

  assign o_a    = {bus2.dut_a, bus1.dut_a, bus0.dut_a};
  assign o_b    = {bus2.dut_b, bus1.dut_b, bus0.dut_b};
  assign o_busy = {bus2.busy,  bus1.busy,  bus0.busy};
  assign o_done = {bus2.done,  bus1.done,  bus0.done};
  assign o_pass = {bus2.pass,  bus1.pass,  bus0.pass};
  assign o_err[0] = bus0.err_count;
  assign o_err[1] = bus1.err_count;
  assign o_err[2] = bus2.err_count;
  assign o_fv[0]  = bus0.fail_vec;
  assign o_fv[1]  = bus1.fail_vec;
  assign o_fv[2]  = bus2.fail_vec;

  typedef struct {
    int               inst;
    int               mode;
    int               settle;
    bit               ign;
    bit               hold;
    logic             pass;
    logic [ERR_W-1:0] err;
    logic [3:0]       fv;
  } vec_t;

  typedef struct {
    int               inst;
    logic             pass;
    logic [ERR_W-1:0] err;
    logic [3:0]       fv;
  } exp_t;

  vec_t tbl [6];
  exp_t sb [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] outs(input int i);
    return {o_a[i], o_b[i], o_busy[i], o_done[i], o_pass[i], o_err[i], o_fv[i]};
  endfunction

  function automatic logic [7:0] results(input int i);
    return {o_pass[i], o_err[i], o_fv[i]};
  endfunction

  task automatic sb_check(input string tag, input int inst);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_sb: done with no expected result queued", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_sb_inst"}, 32'(inst), 32'(e.inst));
    chk({tag, "_sb_res"}, 32'(results(inst)), 32'({e.pass, e.err, e.fv}));
  endtask

  task automatic wait_done(input string tag, input int inst, input int budget);
    bit seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      if (o_done[inst]) begin
        seen = 1'b1;
        sb_check(tag, inst);
      end else begin
        tick();
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  // Cycle-exact sweep check; expects to be entered right after an edge in IDLE
  task automatic run_sweep(input int ti, input vec_t v);
    int         per;
    int         dcyc;
    int         last;
    logic [1:0] vec;
    string      tag;
    per  = v.settle + 1;
    dcyc = 4 * per + 1;
    last = v.hold ? dcyc + 1 : dcyc + 3;
    mode[v.inst]  = v.mode;
    start[v.inst] = 1'b1;
    sb.push_back('{v.inst, v.pass, v.err, v.fv});
    tick();
    for (int c = 1; c <= last; c++) begin
      start[v.inst] = v.hold || (v.ign && (c == 4 || c == 12));
      tag = $sformatf("t%0d_c%0d", ti, c);
      if (c < dcyc) begin
        vec = 2'((c - 1) / per);
        chk({tag, "_ab"}, 32'({o_a[v.inst], o_b[v.inst]}), 32'(vec));
        chk({tag, "_busy_done"}, 32'({o_busy[v.inst], o_done[v.inst]}), 32'b10);
      end else if (c == dcyc) begin
        chk({tag, "_done"}, 32'({o_a[v.inst], o_b[v.inst], o_busy[v.inst], o_done[v.inst]}), 32'b1101);
        sb_check(tag, v.inst);
      end else begin
        chk({tag, "_idle"}, 32'({o_busy[v.inst], o_done[v.inst]}), 32'b00);
        chk({tag, "_hold_res"}, 32'(results(v.inst)), 32'({v.pass, v.err, v.fv}));
      end
      tick();
    end
    if (v.hold) begin
      tag = $sformatf("t%0d_rerun", ti);
      chk({tag, "_busy"}, 32'({o_busy[v.inst], o_a[v.inst], o_b[v.inst], o_pass[v.inst]}), 32'b1000);
      sb.push_back('{v.inst, v.pass, v.err, v.fv});
      start[v.inst] = 1'b0;
      wait_done(tag, v.inst, 4 * per + 4);
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{0, MODE_NAND,   2, 1'b0, 1'b0, 1'b1, 3'd0, 4'b0000};
    tbl[1] = '{0, MODE_STUCK1, 2, 1'b0, 1'b0, 1'b0, 3'd1, 4'b1000};
    tbl[2] = '{0, MODE_AND,    2, 1'b0, 1'b0, 1'b0, 3'd4, 4'b1111};
    tbl[3] = '{1, MODE_AND,    2, 1'b0, 1'b0, 1'b1, 3'd0, 4'b0000};
    tbl[4] = '{0, MODE_NAND,   2, 1'b1, 1'b0, 1'b1, 3'd0, 4'b0000};
    tbl[5] = '{2, MODE_NAND,   4, 1'b0, 1'b1, 1'b1, 3'd0, 4'b0000};

    rst   = 1'b1;
    start = '0;
    mode[0] = MODE_NAND;
    mode[1] = MODE_AND;
    mode[2] = MODE_NAND;
    tick();
    tick();
    for (int i = 0; i < N_INST; i++) begin
      chk($sformatf("reset_inst%0d", i), 32'(outs(i)), 32'd0);
    end
    rst = 1'b0;
    tick();

    foreach (tbl[i]) begin
      run_sweep(i, tbl[i]);
      tick();
    end

    // Reset mid-sweep with a failing gate so partial results are non-zero
    mode[0]  = MODE_AND;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (5) tick();
    chk("rst_partial", 32'({o_busy[0], o_err[0], o_fv[0]}), 32'({1'b1, 3'd1, 4'b0001}));
    rst = 1'b1;
    tick();
    chk("rst_mid_sweep", 32'(outs(0)), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("rst_no_done_%0d", k), 32'({o_busy[0], o_done[0]}), 32'b00);
      tick();
    end
    run_sweep(6, tbl[0]);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
